// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 32x32 register file with write-through bypass and a busy-bit scoreboard for RAW/WAW stall.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueAddr,
  output logic              Busy1,
  output logic              Busy2,
  output logic              Stall,
  output logic [ADDR_W:0]   PendCount
);
  localparam int N = 2**ADDR_W;
  localparam int PW = ADDR_W + 1;
  logic [DATA_W-1:0] regs [N];
  logic [N-1:0] busy;
  logic wr, byp1, byp2, waw, set, clr;
  // Gating with reset_n keeps the bypass from leaking WriteData while reset is held.
  assign wr = reset_n && RegWrite && WriteAddr != '0;
  assign byp1 = wr && WriteAddr == ReadAddr1;
  assign byp2 = wr && WriteAddr == ReadAddr2;
  assign ReadData1 = byp1 ? WriteData : regs[ReadAddr1];
  assign ReadData2 = byp2 ? WriteData : regs[ReadAddr2];
  assign Busy1 = busy[ReadAddr1] && !byp1;
  assign Busy2 = busy[ReadAddr2] && !byp2;
  assign waw = IssueValid && IssueAddr != '0 && busy[IssueAddr] && !(RegWrite && WriteAddr == IssueAddr);
  assign Stall = Busy1 || Busy2 || waw;
  assign set = reset_n && IssueValid && !Stall && IssueAddr != '0;
  // A same-address set overrides the clear, so only a clear that survives counts down.
  assign clr = wr && busy[WriteAddr] && !(set && IssueAddr == WriteAddr);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) regs[i] <= '0;
      busy <= '0;
      PendCount <= '0;
    end else begin
      if (wr) regs[WriteAddr] <= WriteData;
      if (clr) busy[WriteAddr] <= 1'b0;
      if (set) busy[IssueAddr] <= 1'b1;
      PendCount <= PendCount + PW'(set && !busy[IssueAddr]) - PW'(clr);
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed stimulus checked by a per-cycle reference model plus literal expectations.
module tb_regfile_scoreboard;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [4:0]  ReadAddr1 = 0, ReadAddr2 = 0, WriteAddr = 0, IssueAddr = 0;
  logic [31:0] WriteData = 0;
  logic        RegWrite = 0, IssueValid = 0;
  logic [31:0] ReadData1, ReadData2;
  logic        Busy1, Busy2, Stall;
  logic [5:0]  PendCount;
  int total = 0, bad = 0;
  logic [31:0] mregs [32];
  bit   [31:0] mbusy = 0;

  regfile_scoreboard dut (
    .clk(clk), .reset_n(reset_n),
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteAddr(WriteAddr), .WriteData(WriteData), .RegWrite(RegWrite),
    .IssueValid(IssueValid), .IssueAddr(IssueAddr),
    .Busy1(Busy1), .Busy2(Busy2), .Stall(Stall), .PendCount(PendCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", n, got, exp, $time);
    end
  endtask

  function automatic bit m_wr();
    return reset_n && RegWrite && WriteAddr != 0;
  endfunction
  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (!reset_n) return 0;
    if (m_wr() && WriteAddr == a) return WriteData;
    return (a == 0) ? 32'd0 : mregs[a];
  endfunction
  function automatic bit m_busy(input logic [4:0] a);
    return a != 0 && mbusy[a] && !(m_wr() && WriteAddr == a);
  endfunction
  function automatic bit m_stall();
    bit waw;
    waw = IssueValid && IssueAddr != 0 && mbusy[IssueAddr] && !(RegWrite && WriteAddr == IssueAddr);
    return m_busy(ReadAddr1) || m_busy(ReadAddr2) || waw;
  endfunction

  initial for (int i = 0; i < 32; i++) mregs[i] = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mregs[i] <= 0;
      mbusy <= 0;
    end else begin
      if (m_wr()) begin
        mregs[WriteAddr] <= WriteData;
        mbusy[WriteAddr] <= 1'b0;
      end
      if (IssueValid && !m_stall() && IssueAddr != 0) mbusy[IssueAddr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("cmp_rd1", ReadData1, m_rd(ReadAddr1));
    chk("cmp_rd2", ReadData2, m_rd(ReadAddr2));
    chk("cmp_busy1", 32'(Busy1), 32'(m_busy(ReadAddr1)));
    chk("cmp_busy2", 32'(Busy2), 32'(m_busy(ReadAddr2)));
    chk("cmp_stall", 32'(Stall), 32'(m_stall()));
    chk("cmp_pend", 32'(PendCount), 32'($countones(mbusy)));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    step();
    reset_n = 1;
    for (int a = 0; a < 32; a++) begin
      ReadAddr1 = 5'(a);
      ReadAddr2 = 5'(31 - a);
      #1;
      chk("reset_rd1", ReadData1, 0);
      chk("reset_rd2", ReadData2, 0);
    end
    chk("reset_pend", 32'(PendCount), 0);
    chk("reset_stall", 32'(Stall), 0);
    step();
    RegWrite = 1; WriteAddr = 5; WriteData = 32'hDEADBEEF; ReadAddr1 = 5; ReadAddr2 = 0;
    #1 chk("bypass_rd1", ReadData1, 32'hDEADBEEF);
    step();
    RegWrite = 0;
    #1 chk("stored_rd1", ReadData1, 32'hDEADBEEF);
    RegWrite = 1; WriteAddr = 0; WriteData = 32'hFFFFFFFF; ReadAddr1 = 0;
    #1 chk("r0_bypass", ReadData1, 0);
    step();
    RegWrite = 0;
    #1 chk("r0_stored", ReadData1, 0);
    IssueValid = 1; IssueAddr = 7;
    #1 chk("iss7_stall", 32'(Stall), 0);
    step();
    IssueValid = 0; ReadAddr2 = 7;
    #1 chk("raw_busy2", 32'(Busy2), 1);
    chk("raw_stall", 32'(Stall), 1);
    chk("raw_pend", 32'(PendCount), 1);
    RegWrite = 1; WriteAddr = 7; WriteData = 32'h12;
    #1 chk("wb_busy2", 32'(Busy2), 0);
    chk("wb_rd2", ReadData2, 32'h12);
    step();
    RegWrite = 0;
    #1 chk("wb_pend", 32'(PendCount), 0);
    ReadAddr2 = 0; IssueValid = 1; IssueAddr = 9;
    step();
    #1 chk("waw_stall", 32'(Stall), 1);
    chk("waw_pend", 32'(PendCount), 1);
    step();
    chk("waw_pend_hold", 32'(PendCount), 1);
    RegWrite = 1; WriteAddr = 9; WriteData = 32'h99;
    #1 chk("setclr_stall", 32'(Stall), 0);
    step();
    RegWrite = 0; IssueValid = 0; ReadAddr1 = 9;
    #1 chk("setclr_pend", 32'(PendCount), 1);
    chk("setclr_busy1", 32'(Busy1), 1);
    RegWrite = 1; WriteAddr = 9; WriteData = 32'h9A;
    step();
    RegWrite = 0; ReadAddr1 = 0;
    #1 chk("clr9_pend", 32'(PendCount), 0);
    IssueValid = 1; IssueAddr = 10;
    step();
    IssueAddr = 11; RegWrite = 1; WriteAddr = 10; WriteData = 32'hA;
    step();
    IssueValid = 0; RegWrite = 0;
    #1 chk("diff_setclr_pend", 32'(PendCount), 1);
    RegWrite = 1; WriteAddr = 11;
    step();
    RegWrite = 0; IssueValid = 1; IssueAddr = 3;
    step();
    IssueAddr = 4;
    step();
    IssueAddr = 6;
    step();
    IssueValid = 0;
    #1 chk("three_pend", 32'(PendCount), 3);
    RegWrite = 1; WriteAddr = 8; WriteData = 32'h88;
    step();
    RegWrite = 0; ReadAddr1 = 5; ReadAddr2 = 3;
    #1 chk("nonbusy_wr_pend", 32'(PendCount), 3);
    chk("pre_rst_rd1", ReadData1, 32'hDEADBEEF);
    reset_n = 0;
    #1 chk("async_pend", 32'(PendCount), 0);
    chk("async_rd1", ReadData1, 0);
    chk("async_busy2", 32'(Busy2), 0);
    RegWrite = 1; WriteAddr = 5; WriteData = 32'h55; IssueValid = 1; IssueAddr = 12;
    step();
    RegWrite = 0; IssueValid = 0;
    step();
    reset_n = 1;
    #1 chk("post_rst_rd1", ReadData1, 0);
    chk("post_rst_pend", 32'(PendCount), 0);
    ReadAddr1 = 0; ReadAddr2 = 0; IssueValid = 1; IssueAddr = 0;
    #1 chk("iss0_stall", 32'(Stall), 0);
    step();
    IssueValid = 0;
    #1 chk("iss0_pend", 32'(PendCount), 0);
    chk("iss0_busy1", 32'(Busy1), 0);
    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- 32 x 32-bit register file with two combinational read ports and one write port.
- The write port takes its destination address from the 5-bit RegDst address mux output.
- An integrated scoreboard holds one busy bit per register and a pending-write counter, and drives the decode-stage stall for RAW and WAW hazards.
- Sits between instruction decode/issue (upstream) and the execute/write-back path (downstream).

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 5, register address width; the register count is 2**ADDR_W (32).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- ReadAddr1  input  ADDR_W  read port 1 address (rs).
- ReadAddr2  input  ADDR_W  read port 2 address (rt).
- ReadData1  output  DATA_W  read port 1 data.
- ReadData2  output  DATA_W  read port 2 data.
- WriteAddr  input  ADDR_W  write-back destination, driven by the RegDst address mux.
- WriteData  input  DATA_W  write-back data.
- RegWrite  input  1  write enable; also clears the busy bit of WriteAddr.
- IssueValid  input  1  an instruction requests issue this cycle.
- IssueAddr  input  ADDR_W  destination the issuing instruction will write.
- Busy1  output  1  port 1 source still has a pending write (RAW hazard).
- Busy2  output  1  port 2 source still has a pending write (RAW hazard).
- Stall  output  1  issue is blocked this cycle.
- PendCount  output  ADDR_W+1  number of registers currently marked busy.

Behaviour:
- Reset: asynchronous on reset_n low, effective immediately, mid-operation included.
  - All registers go to 0 and all busy bits clear.
  - PendCount = 0; Busy1 = Busy2 = Stall = 0; ReadData1/2 = 0.
  - Writes and issues presented during reset are discarded.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - It is never marked busy, and issues to it never alter the scoreboard.
- Write: at posedge clk, when RegWrite=1 and WriteAddr!=0, regs[WriteAddr] <= WriteData.
- Read: combinational, zero latency.
  - Write-through bypass: if RegWrite=1, WriteAddr!=0 and WriteAddr==ReadAddrN, then ReadDataN = WriteData in the same cycle.
  - Otherwise ReadDataN = regs[ReadAddrN].
- Busy flags: BusyN = busy[ReadAddrN] AND NOT bypassN, where bypassN is the bypass condition above. A same-cycle write-back resolves the hazard.
- WAW hazard: waw = IssueValid AND IssueAddr!=0 AND busy[IssueAddr] AND NOT (RegWrite AND WriteAddr==IssueAddr).
- Stall = Busy1 OR Busy2 OR waw. Stall is evaluated whether or not IssueValid is asserted.
- Issue is accepted when IssueValid=1 AND Stall=0.
  - On acceptance with IssueAddr!=0, busy[IssueAddr] sets at the posedge.
  - A stalled issue changes no state; upstream holds IssueValid and IssueAddr until acceptance.
- Clear: RegWrite=1 with WriteAddr!=0 clears busy[WriteAddr] at the posedge.
  - A write to a non-busy register still performs the data write.
  - It changes no busy bit and does not touch PendCount, so there is no underflow.
- Simultaneous clear and set on the same address: set wins. The bit stays 1 and PendCount is unchanged.
- PendCount: +1 on a set of a previously-clear bit; -1 on a clear of a previously-set bit that is not re-set in the same cycle.
  - A set and a clear on different addresses in the same cycle leave PendCount unchanged.
  - Range is 0..31; saturation is never needed.
- All sequential state updates on the rising clk edge only; there is no other latency.

Test Plan:
- Reset, then read all 32 addresses -> every ReadData = 0, PendCount = 0, Stall = 0.
- RegWrite=1, WriteAddr=5, WriteData=0xDEADBEEF with ReadAddr1=5 in the same cycle -> ReadData1 = 0xDEADBEEF combinationally (bypass) and on every later cycle. RegWrite=1, WriteAddr=0, WriteData=0xFFFFFFFF -> reading address 0 returns 0.
- Issue IssueAddr=7 (accepted), next cycle ReadAddr2=7 -> Busy2=1, Stall=1, PendCount=1. Then RegWrite to 7 with 0x12 -> Busy2=0 in that cycle with ReadData2=0x12; next cycle PendCount=0.
- Issue to 9 accepted; issue to 9 again with no write-back -> Stall=1 (WAW) and PendCount stays 1. Same-cycle RegWrite to 9 plus issue to 9 -> issue accepted, busy[9] stays 1, PendCount stays 1.
- Issue to 3, 4 and 6 on consecutive cycles -> PendCount = 3. Drop reset_n mid-cycle -> PendCount, busy bits and registers read 0 immediately, without waiting for a clock edge.
- Issue to 0 -> Stall=0, PendCount unchanged, Busy never set for address 0.
